// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and default widths for decode/write-back stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

   localparam int MIPS_DATA_W = 32;
   localparam int MIPS_ADDR_W = 5;

   typedef logic [MIPS_DATA_W-1:0] reg_data_t;
   typedef logic [MIPS_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Register-file bus: two read ports, one issue port, two write-back ports.
// Latency: reads combinational, writes/issues take effect on the next edge.
// Backpressure: none; every issue and write is accepted when presented.
interface reg_file_sb_if
   import mips_pkg::*;
#(
   parameter int DATA_W = MIPS_DATA_W,
   parameter int ADDR_W = MIPS_ADDR_W
);

   logic [ADDR_W-1:0] REG_address1;
   logic [ADDR_W-1:0] REG_address2;
   logic [DATA_W-1:0] REG_data_out1;
   logic [DATA_W-1:0] REG_data_out2;
   logic              REG_busy_out1;
   logic              REG_busy_out2;
   logic              REG_issue;
   logic [ADDR_W-1:0] REG_address_issue;
   logic              REG_write_0;
   logic              REG_write_1;
   logic [ADDR_W-1:0] REG_address_wr0;
   logic [ADDR_W-1:0] REG_address_wr1;
   logic [DATA_W-1:0] REG_data_wb_in0;
   logic [DATA_W-1:0] REG_data_wb_in1;
   logic [ADDR_W:0]   REG_busy_count;

   // Pipeline side: decode drives addresses/issue, write-back drives results.
   modport master (
      output REG_address1, REG_address2,
      output REG_issue, REG_address_issue,
      output REG_write_0, REG_write_1,
      output REG_address_wr0, REG_address_wr1,
      output REG_data_wb_in0, REG_data_wb_in1,
      input  REG_data_out1, REG_data_out2,
      input  REG_busy_out1, REG_busy_out2,
      input  REG_busy_count
   );

   // Register-file side.
   modport slave (
      input  REG_address1, REG_address2,
      input  REG_issue, REG_address_issue,
      input  REG_write_0, REG_write_1,
      input  REG_address_wr0, REG_address_wr1,
      input  REG_data_wb_in0, REG_data_wb_in1,
      output REG_data_out1, REG_data_out2,
      output REG_busy_out1, REG_busy_out2,
      output REG_busy_count
   );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: per-register pending-write bits plus a running busy count.
// Latency: set/clear and count visible 1 cycle after the edge.
// Backpressure: none; issue and both clears are applied every cycle.
module reg_scoreboard
   import mips_pkg::*;
#(
   parameter int ADDR_W   = MIPS_ADDR_W,
   parameter int ZERO_REG = 1
)(
   input  logic                   SYS_clk,
   input  logic                   SYS_rst_n,
   input  logic                   i_issue,
   input  logic [ADDR_W-1:0]      i_addr_issue,
   input  logic                   i_wr0,
   input  logic [ADDR_W-1:0]      i_addr_wr0,
   input  logic                   i_wr1,
   input  logic [ADDR_W-1:0]      i_addr_wr1,
   output logic [(1<<ADDR_W)-1:0] o_busy,
   output logic [ADDR_W:0]        o_busy_count
);

   localparam int NUM_REGS = 1 << ADDR_W;
   localparam int CNT_W    = ADDR_W + 1;

   logic [NUM_REGS-1:0] r_busy;
   logic [CNT_W-1:0]    r_count;
   logic [NUM_REGS-1:0] w_busy_next;
   logic                w_set_v;
   logic                w_clr0_v;
   logic                w_clr1_v;
   logic                w_rise;
   logic                w_fall0;
   logic                w_fall1;

   // Register 0 is hard-wired when ZERO_REG is set, so its traffic is dropped here.
   assign w_set_v  = i_issue && !((ZERO_REG != 0) && (i_addr_issue == '0));
   assign w_clr0_v = i_wr0   && !((ZERO_REG != 0) && (i_addr_wr0   == '0));
   assign w_clr1_v = i_wr1   && !((ZERO_REG != 0) && (i_addr_wr1   == '0));

   // Transitions against the live busy vector: a set overrides a clear on the
   // same register, and a dual write to one register counts as a single fall.
   assign w_rise  = w_set_v && !r_busy[i_addr_issue];
   assign w_fall0 = w_clr0_v && r_busy[i_addr_wr0]
                    && !(w_set_v && (i_addr_issue == i_addr_wr0));
   assign w_fall1 = w_clr1_v && r_busy[i_addr_wr1]
                    && !(w_set_v && (i_addr_issue == i_addr_wr1))
                    && !(w_clr0_v && (i_addr_wr0 == i_addr_wr1));

   // Next busy vector: clears first, then the issue so that set wins.
   always_comb begin
      w_busy_next = r_busy;
      if (w_clr0_v) w_busy_next[i_addr_wr0]   = 1'b0;
      if (w_clr1_v) w_busy_next[i_addr_wr1]   = 1'b0;
      if (w_set_v)  w_busy_next[i_addr_issue] = 1'b1;
   end

   // Busy state and counter; reset drops all pending writes.
   always_ff @(posedge SYS_clk) begin
      if (!SYS_rst_n) begin
         r_busy  <= '0;
         r_count <= '0;
      end else begin
         r_busy  <= w_busy_next;
         r_count <= r_count + CNT_W'(w_rise) - CNT_W'(w_fall0) - CNT_W'(w_fall1);
      end
   end

   assign o_busy       = r_busy;
   assign o_busy_count = r_count;

endmodule

// File: rtl/reg_file_sb.sv
// Decode-stage register file with two read ports, two write-back ports and busy scoreboard.
// Latency: reads 0 cycles (optionally bypassing same-cycle writes), writes 1 cycle.
// Backpressure: none; all writes and issues are accepted in the cycle presented.
module reg_file_sb
   import mips_pkg::*;
#(
   parameter int DATA_W   = MIPS_DATA_W,
   parameter int ADDR_W   = MIPS_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
)(
   input  logic         SYS_clk,
   input  logic         SYS_rst_n,
   reg_file_sb_if.slave bus
);

   localparam int NUM_REGS = 1 << ADDR_W;

   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] w_busy;
   logic                w_wr0_v;
   logic                w_wr1_v;
   logic                w_iss_v;
   logic [ADDR_W-1:0]   w_rd_addr [2];
   logic [DATA_W-1:0]   w_rd_data [2];
   logic                w_rd_busy [2];

   assign w_wr0_v = bus.REG_write_0 && !((ZERO_REG != 0) && (bus.REG_address_wr0 == '0));
   assign w_wr1_v = bus.REG_write_1 && !((ZERO_REG != 0) && (bus.REG_address_wr1 == '0));
   assign w_iss_v = bus.REG_issue   && !((ZERO_REG != 0) && (bus.REG_address_issue == '0));

   reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .SYS_clk      (SYS_clk),
      .SYS_rst_n    (SYS_rst_n),
      .i_issue      (bus.REG_issue),
      .i_addr_issue (bus.REG_address_issue),
      .i_wr0        (bus.REG_write_0),
      .i_addr_wr0   (bus.REG_address_wr0),
      .i_wr1        (bus.REG_write_1),
      .i_addr_wr1   (bus.REG_address_wr1),
      .o_busy       (w_busy),
      .o_busy_count (bus.REG_busy_count)
   );

   // Storage: port 1 is written last so it wins a same-address collision.
   always_ff @(posedge SYS_clk) begin
      if (!SYS_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         if (w_wr0_v) r_regs[bus.REG_address_wr0] <= bus.REG_data_wb_in0;
         if (w_wr1_v) r_regs[bus.REG_address_wr1] <= bus.REG_data_wb_in1;
      end
   end

   assign w_rd_addr[0] = bus.REG_address1;
   assign w_rd_addr[1] = bus.REG_address2;

   // Read muxes: bypass a matching write (port 1 first); a forwarded result is
   // not busy unless the same register is being re-issued this cycle.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rd_data[p] = r_regs[w_rd_addr[p]];
         w_rd_busy[p] = w_busy[w_rd_addr[p]];
         if (BYPASS != 0) begin
            if (w_wr1_v && (bus.REG_address_wr1 == w_rd_addr[p])) begin
               w_rd_data[p] = bus.REG_data_wb_in1;
               w_rd_busy[p] = w_iss_v && (bus.REG_address_issue == w_rd_addr[p]);
            end else if (w_wr0_v && (bus.REG_address_wr0 == w_rd_addr[p])) begin
               w_rd_data[p] = bus.REG_data_wb_in0;
               w_rd_busy[p] = w_iss_v && (bus.REG_address_issue == w_rd_addr[p]);
            end
         end
         if ((ZERO_REG != 0) && (w_rd_addr[p] == '0)) begin
            w_rd_data[p] = '0;
            w_rd_busy[p] = 1'b0;
         end
      end
   end

   assign bus.REG_data_out1 = w_rd_data[0];
   assign bus.REG_data_out2 = w_rd_data[1];
   assign bus.REG_busy_out1 = w_rd_busy[0];
   assign bus.REG_busy_out2 = w_rd_busy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one bypassing and one non-bypassing instance.
// Latency: checks reads combinationally and stored state one edge later.
// Backpressure: none exercised; the design has none.
module tb_reg_file_sb;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_addr_t a1, a2, aiss, aw0, aw1;
   reg_data_t d0, d1;
   logic      iss, w0, w1;

   int checks = 0;
   int errors = 0;

   reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
   reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

   assign ifa.REG_address1 = a1;   assign ifb.REG_address1 = a1;
   assign ifa.REG_address2 = a2;   assign ifb.REG_address2 = a2;
   assign ifa.REG_issue = iss;     assign ifb.REG_issue = iss;
   assign ifa.REG_address_issue = aiss; assign ifb.REG_address_issue = aiss;
   assign ifa.REG_write_0 = w0;    assign ifb.REG_write_0 = w0;
   assign ifa.REG_write_1 = w1;    assign ifb.REG_write_1 = w1;
   assign ifa.REG_address_wr0 = aw0; assign ifb.REG_address_wr0 = aw0;
   assign ifa.REG_address_wr1 = aw1; assign ifb.REG_address_wr1 = aw1;
   assign ifa.REG_data_wb_in0 = d0; assign ifb.REG_data_wb_in0 = d0;
   assign ifa.REG_data_wb_in1 = d1; assign ifb.REG_data_wb_in1 = d1;

   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .SYS_clk(clk), .SYS_rst_n(rst_n), .bus(ifa.slave));
   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
      .SYS_clk(clk), .SYS_rst_n(rst_n), .bus(ifb.slave));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      iss = 1'b0; w0 = 1'b0; w1 = 1'b0;
      aiss = '0; aw0 = '0; aw1 = '0; d0 = '0; d1 = '0;
   endtask

   // Advance one rising edge, then return 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; a1 = '0; a2 = '0;
      idle();
      // Reset edge with live issue/write that must be ignored.
      iss = 1'b1; aiss = 5'd5; w0 = 1'b1; aw0 = 5'd5; d0 = 32'hAAAA;
      tick();
      rst_n = 1'b1; idle();
      a1 = 5'd5; a2 = 5'd31; #1;
      check("rst_data1", ifa.REG_data_out1, 32'h0);
      check("rst_data2", ifa.REG_data_out2, 32'h0);
      check("rst_busy1", ifa.REG_busy_out1, 1'b0);
      check("rst_busy2", ifa.REG_busy_out2, 1'b0);
      check("rst_count", ifa.REG_busy_count, 6'd0);
      check("rst_b_data1", ifb.REG_data_out1, 32'h0);

      // Issue r7, then retire it from the ALU port.
      iss = 1'b1; aiss = 5'd7; tick(); idle();
      a1 = 5'd7; #1;
      check("iss7_busy", ifa.REG_busy_out1, 1'b1);
      check("iss7_count", ifa.REG_busy_count, 6'd1);
      w1 = 1'b1; aw1 = 5'd7; d1 = 32'hDEAD_BEEF; #1;
      check("wb7_byp_data", ifa.REG_data_out1, 32'hDEAD_BEEF);
      check("wb7_byp_busy", ifa.REG_busy_out1, 1'b0);
      tick(); idle(); #1;
      check("wb7_data", ifa.REG_data_out1, 32'hDEAD_BEEF);
      check("wb7_busy", ifa.REG_busy_out1, 1'b0);
      check("wb7_count", ifa.REG_busy_count, 6'd0);

      // Write to a register that is not busy.
      w0 = 1'b1; aw0 = 5'd7; d0 = 32'h0BAD; tick(); idle(); #1;
      check("nb_data", ifa.REG_data_out1, 32'h0BAD);
      check("nb_busy", ifa.REG_busy_out1, 1'b0);
      check("nb_count", ifa.REG_busy_count, 6'd0);

      // Bypass vs no bypass on r3.
      w0 = 1'b1; aw0 = 5'd3; d0 = 32'h1111; tick(); idle();
      a1 = 5'd3; w0 = 1'b1; aw0 = 5'd3; d0 = 32'h1234; #1;
      check("byp_a_data", ifa.REG_data_out1, 32'h1234);
      check("byp_b_old", ifb.REG_data_out1, 32'h1111);
      tick(); idle(); #1;
      check("byp_b_new", ifb.REG_data_out1, 32'h1234);

      // Dual write to r9: port 1 wins, busy cleared once.
      iss = 1'b1; aiss = 5'd9; tick(); idle();
      a1 = 5'd9;
      w0 = 1'b1; aw0 = 5'd9; d0 = 32'hAAAA;
      w1 = 1'b1; aw1 = 5'd9; d1 = 32'h5555; #1;
      check("dual_byp_data", ifa.REG_data_out1, 32'h5555);
      tick(); idle(); #1;
      check("dual_data", ifa.REG_data_out1, 32'h5555);
      check("dual_busy", ifa.REG_busy_out1, 1'b0);
      check("dual_count", ifa.REG_busy_count, 6'd0);
      check("dual_b_data", ifb.REG_data_out1, 32'h5555);

      // Issue r9 while writing r9: set wins, data still written.
      iss = 1'b1; aiss = 5'd9; tick(); idle();
      iss = 1'b1; aiss = 5'd9; w1 = 1'b1; aw1 = 5'd9; d1 = 32'h7777; #1;
      check("iw_byp_busy", ifa.REG_busy_out1, 1'b1);
      check("iw_byp_data", ifa.REG_data_out1, 32'h7777);
      tick(); idle(); #1;
      check("iw_busy", ifa.REG_busy_out1, 1'b1);
      check("iw_count", ifa.REG_busy_count, 6'd1);
      check("iw_data", ifa.REG_data_out1, 32'h7777);
      w0 = 1'b1; aw0 = 5'd9; d0 = 32'h8888; tick(); idle();

      // Zero register ignores writes and issues.
      a1 = 5'd0;
      w0 = 1'b1; aw0 = 5'd0; d0 = 32'hFFFF_FFFF;
      w1 = 1'b1; aw1 = 5'd0; d1 = 32'hFFFF_FFFF;
      iss = 1'b1; aiss = 5'd0; #1;
      check("r0_byp_data", ifa.REG_data_out1, 32'h0);
      check("r0_byp_busy", ifa.REG_busy_out1, 1'b0);
      check("r0_b_data", ifb.REG_data_out1, 32'h0);
      tick(); idle(); #1;
      check("r0_data", ifa.REG_data_out1, 32'h0);
      check("r0_busy", ifa.REG_busy_out1, 1'b0);
      check("r0_count", ifa.REG_busy_count, 6'd0);

      // Fill the scoreboard r1..r31.
      for (int i = 1; i < 32; i++) begin
         iss = 1'b1; aiss = 5'(i); tick();
      end
      idle(); a1 = 5'd1; a2 = 5'd31; #1;
      check("fill_count", ifa.REG_busy_count, 6'd31);
      check("fill_busy1", ifa.REG_busy_out1, 1'b1);
      check("fill_busy31", ifa.REG_busy_out2, 1'b1);
      iss = 1'b1; aiss = 5'd5; tick(); idle(); #1;
      check("reissue_count", ifa.REG_busy_count, 6'd31);
      w0 = 1'b1; aw0 = 5'd1; d0 = 32'h11; w1 = 1'b1; aw1 = 5'd2; d1 = 32'h22;
      tick(); idle(); a1 = 5'd1; a2 = 5'd2; #1;
      check("dual_clr_count", ifa.REG_busy_count, 6'd29);
      check("dual_clr_busy1", ifa.REG_busy_out1, 1'b0);
      check("dual_clr_busy2", ifa.REG_busy_out2, 1'b0);
      check("dual_clr_b_count", ifb.REG_busy_count, 6'd29);

      // Reset mid-operation drops pending state and stored data.
      rst_n = 1'b0; iss = 1'b1; aiss = 5'd1; tick();
      rst_n = 1'b1; idle(); a1 = 5'd31; a2 = 5'd7; #1;
      check("mrst_busy31", ifa.REG_busy_out1, 1'b0);
      check("mrst_busy7", ifa.REG_busy_out2, 1'b0);
      check("mrst_count", ifa.REG_busy_count, 6'd0);
      check("mrst_data7", ifa.REG_data_out2, 32'h0);
      check("mrst_data31", ifa.REG_data_out1, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
